// File: rtl/bt_pipe_packer.sv
// Sample-to-pipe packer with a FWFT word FIFO and block-throttled ready for okBTPipeOut.
// A flush pads the partial word and then the partial block so the host can drain the tail.
module bt_pipe_packer #(
  parameter int          IN_W        = 32,
  parameter int          SAMPLE_W    = 8,
  parameter int          SAMPLE_LSB  = 2,
  parameter int          DEPTH       = 1024,
  parameter int          BLOCK_WORDS = 256,
  parameter logic [31:0] PAD_WORD    = 32'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       in_valid,
  input  logic                       flush,
  input  logic                       ep_read,
  output logic [31:0]                ep_datain,
  output logic                       ep_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       flush_busy,
  output logic [15:0]                drop_cnt,
  output logic                       underflow
);

  localparam int PACK   = 32 / SAMPLE_W;
  localparam int SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int LVL_W  = AW + 1;
  localparam int BLK_W  = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PAD_WORD = 2'd1,
    S_PAD_BLK  = 2'd2
  } state_t;

  logic [31:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              underflow_q, underflow_d;
  logic [15:0]       drop_q, drop_d;
  logic [31:0]       pack_q, pack_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              pend_q, pend_d;
  logic [31:0]       pend_word_q, pend_word_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  state_t            state_q, state_d;
  logic              busy_q;

  logic [SAMPLE_W-1:0] sample;
  logic [31:0]         merged;
  logic                slot_last;
  logic                accept;
  logic                full;
  logic                empty;
  logic                rd_en;
  logic                wr_req;
  logic                wr_en;
  logic [31:0]         wr_data;
  logic [1:0]          drops;
  logic [16:0]         drop_sum;
  logic                unused_in;

  assign sample    = in_data[SAMPLE_LSB +: SAMPLE_W];
  assign unused_in = ^in_data;
  assign slot_last = (slot_q == SLOT_W'(PACK - 1));
  assign accept    = in_valid && (state_q == S_IDLE);
  assign full      = (level_q == LVL_W'(DEPTH));
  assign empty     = (level_q == '0);
  assign rd_en     = ep_read && !empty;

  always_comb begin
    merged = pack_q;
    merged[int'(slot_q) * SAMPLE_W +: SAMPLE_W] = sample;
  end

  // The pending packer word owns the write port; the flush FSM only writes when it is free.
  always_comb begin
    pack_d      = pack_q;
    slot_d      = slot_q;
    pend_d      = 1'b0;
    pend_word_d = pend_word_q;
    wr_req      = 1'b0;
    wr_data     = pend_word_q;
    drops       = 2'd0;

    if (pend_q) begin
      wr_req  = 1'b1;
      wr_data = pend_word_q;
    end

    if (accept) begin
      if (slot_last) begin
        pend_d      = 1'b1;
        pend_word_d = merged;
        pack_d      = '0;
        slot_d      = '0;
      end else begin
        pack_d = merged;
        slot_d = slot_q + SLOT_W'(1);
      end
    end

    if (in_valid && (state_q != S_IDLE)) begin
      drops = drops + 2'd1;
    end

    case (state_q)
      S_PAD_WORD: begin
        if (!pend_q && !full) begin
          wr_req  = 1'b1;
          wr_data = pack_q;
          pack_d  = '0;
          slot_d  = '0;
        end
      end
      S_PAD_BLK: begin
        if (!pend_q && !full) begin
          wr_req  = 1'b1;
          wr_data = PAD_WORD;
        end
      end
      default: ;
    endcase

    wr_en = wr_req && !full;
    if (wr_req && full) begin
      drops = drops + 2'd1;
    end
  end

  always_comb begin
    blk_d = blk_q;
    if (wr_en) begin
      if (blk_q == BLK_W'(BLOCK_WORDS - 1)) begin
        blk_d = '0;
      end else begin
        blk_d = blk_q + BLK_W'(1);
      end
    end
  end

  // Flush decisions look at the post-write state so a word landing this edge is counted first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          if (slot_d != '0) begin
            state_d = S_PAD_WORD;
          end else if ((blk_d != '0) || pend_d) begin
            state_d = S_PAD_BLK;
          end
        end
      end
      S_PAD_WORD: begin
        if (wr_en && !pend_q) begin
          state_d = (blk_d == '0) ? S_IDLE : S_PAD_BLK;
        end
      end
      S_PAD_BLK: begin
        if ((blk_d == '0) && (wr_en || pend_q)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    underflow_d = underflow_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (ep_read && empty) begin
      underflow_d = 1'b1;
    end

    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    drop_sum = {1'b0, drop_q} + 17'(drops);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
      drop_q      <= '0;
      pack_q      <= '0;
      slot_q      <= '0;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
      blk_q       <= '0;
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      underflow_q <= underflow_d;
      drop_q      <= drop_d;
      pack_q      <= pack_d;
      slot_q      <= slot_d;
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
      blk_q       <= blk_d;
      state_q     <= state_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign ep_datain  = empty ? 32'h0 : mem[rd_ptr_q];
  assign ep_ready   = (level_q >= LVL_W'(BLOCK_WORDS));
  assign level      = level_q;
  assign flush_busy = busy_q;
  assign drop_cnt   = drop_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_bt_pipe_packer.sv
// Directed bench for bt_pipe_packer: per-cycle vector table plus hand-built full/flush/reset sequences.
module tb_bt_pipe_packer;

  localparam logic [31:0] PADW = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        flush;
  logic        ep_read;
  logic [31:0] ep_datain;
  logic        ep_ready;
  logic [4:0]  level;
  logic        flush_busy;
  logic [15:0] drop_cnt;
  logic        underflow;

  int n_pass  = 0;
  int n_total = 0;

  bt_pipe_packer #(
    .IN_W(32), .SAMPLE_W(8), .SAMPLE_LSB(2), .DEPTH(16), .BLOCK_WORDS(4), .PAD_WORD(PADW)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .flush(flush),
    .ep_read(ep_read), .ep_datain(ep_datain), .ep_ready(ep_ready), .level(level),
    .flush_busy(flush_busy), .drop_cnt(drop_cnt), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  s;
    logic        rd;
    logic        fl;
    int          lvl;
    logic        rdy;
    logic        busy;
    logic [31:0] head;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] s, input logic rd, input logic fl,
                     input int lvl, input logic rdy, input logic busy, input logic [31:0] head);
    vec_t e;
    e.v = v; e.s = s; e.rd = rd; e.fl = fl;
    e.lvl = lvl; e.rdy = rdy; e.busy = busy; e.head = head;
    tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Sample field sits at [9:2]; surrounding bits are set to catch a wrong extraction offset.
  task automatic step(input logic v, input logic [7:0] s, input logic rd, input logic fl);
    @(negedge clk);
    in_valid = v;
    in_data  = {22'h3FFFFF, s, 2'b11};
    ep_read  = rd;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pop_chk(input string nm, input logic [31:0] exp);
    chk(nm, ep_datain, exp);
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [7:0]  b;
    int          budget;

    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; ep_read = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_ready", 32'(ep_ready), 0);
    chk("rst_busy", 32'(flush_busy), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_head", ep_datain, 0);
    @(negedge clk);
    reset = 1'b0;

    // packing, block ready, read+write, flush with partial word and partial block, no-op flush
    add(1, 8'h01, 0, 0, 0, 0, 0, 32'h0);
    add(1, 8'h02, 0, 0, 0, 0, 0, 32'h0);
    add(1, 8'h03, 0, 0, 0, 0, 0, 32'h0);
    add(1, 8'h04, 0, 0, 0, 0, 0, 32'h0);
    add(0, 8'h00, 0, 0, 1, 0, 0, 32'h04030201);
    add(1, 8'h05, 0, 0, 1, 0, 0, 32'h04030201);
    add(1, 8'h06, 0, 0, 1, 0, 0, 32'h04030201);
    add(1, 8'h07, 0, 0, 1, 0, 0, 32'h04030201);
    add(1, 8'h08, 0, 0, 1, 0, 0, 32'h04030201);
    add(1, 8'h09, 0, 0, 2, 0, 0, 32'h04030201);
    add(1, 8'h0A, 0, 0, 2, 0, 0, 32'h04030201);
    add(1, 8'h0B, 0, 0, 2, 0, 0, 32'h04030201);
    add(1, 8'h0C, 0, 0, 2, 0, 0, 32'h04030201);
    add(1, 8'h0D, 0, 0, 3, 0, 0, 32'h04030201);
    add(1, 8'h0E, 0, 0, 3, 0, 0, 32'h04030201);
    add(1, 8'h0F, 0, 0, 3, 0, 0, 32'h04030201);
    add(1, 8'h10, 0, 0, 3, 0, 0, 32'h04030201);
    add(0, 8'h00, 0, 0, 4, 1, 0, 32'h04030201);
    add(0, 8'h00, 1, 0, 3, 0, 0, 32'h08070605);
    add(1, 8'h11, 0, 0, 3, 0, 0, 32'h08070605);
    add(1, 8'h12, 0, 0, 3, 0, 0, 32'h08070605);
    add(1, 8'h13, 0, 0, 3, 0, 0, 32'h08070605);
    add(1, 8'h14, 0, 0, 3, 0, 0, 32'h08070605);
    add(0, 8'h00, 1, 0, 3, 0, 0, 32'h0C0B0A09);
    add(1, 8'hAA, 0, 0, 3, 0, 0, 32'h0C0B0A09);
    add(1, 8'hBB, 0, 0, 3, 0, 0, 32'h0C0B0A09);
    add(0, 8'h00, 0, 1, 3, 0, 1, 32'h0C0B0A09);
    add(0, 8'h00, 0, 0, 4, 1, 1, 32'h0C0B0A09);
    add(0, 8'h00, 0, 0, 5, 1, 1, 32'h0C0B0A09);
    add(0, 8'h00, 0, 0, 6, 1, 0, 32'h0C0B0A09);
    add(0, 8'h00, 1, 0, 5, 1, 0, 32'h100F0E0D);
    add(0, 8'h00, 1, 0, 4, 1, 0, 32'h14131211);
    add(0, 8'h00, 1, 0, 3, 0, 0, 32'h0000BBAA);
    add(0, 8'h00, 1, 0, 2, 0, 0, PADW);
    add(0, 8'h00, 1, 0, 1, 0, 0, PADW);
    add(0, 8'h00, 1, 0, 0, 0, 0, 32'h0);
    add(0, 8'h00, 0, 1, 0, 0, 0, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].rd, tbl[i].fl);
      chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("v%0d_ready", i), 32'(ep_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_busy", i), 32'(flush_busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_head", i), ep_datain, tbl[i].head);
    end
    chk("tbl_drop", 32'(drop_cnt), 0);
    chk("tbl_underflow", 32'(underflow), 0);

    // samples during a flush are dropped; a second flush pulse while busy is ignored
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("f2_busy0", 32'(flush_busy), 1);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    chk("f2_drop", 32'(drop_cnt), 1);
    chk("f2_level1", 32'(level), 1);
    idle();
    idle();
    chk("f2_busy_pre", 32'(flush_busy), 1);
    idle();
    chk("f2_busy_end", 32'(flush_busy), 0);
    chk("f2_level4", 32'(level), 4);
    idle();
    chk("f2_no_reflush", 32'(level), 4);
    pop_chk("f2_w0", 32'h00000077);
    pop_chk("f2_w1", PADW);
    pop_chk("f2_w2", PADW);
    pop_chk("f2_w3", PADW);
    chk("f2_empty", 32'(level), 0);

    // fill to DEPTH, overflow two words, then a flush that must stall until reads free space
    for (int i = 0; i < 16; i++) begin
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) begin
        b = 8'(i * 4 + k + 1);
        w[k*8 +: 8] = b;
        step(1'b1, b, 1'b0, 1'b0);
      end
      exp_q.push_back(w);
    end
    for (int j = 0; j < 8; j++) begin
      step(1'b1, 8'(8'hE0 + j), 1'b0, 1'b0);
    end
    idle();
    chk("full_level", 32'(level), 16);
    chk("full_drop", 32'(drop_cnt), 3);
    chk("full_head", ep_datain, 32'h04030201);
    chk("full_ready", 32'(ep_ready), 1);
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int j = 0; j < 3; j++) begin
      idle();
      chk($sformatf("stall%0d_busy", j), 32'(flush_busy), 1);
      chk($sformatf("stall%0d_level", j), 32'(level), 16);
    end
    exp_q.push_back(32'h0000C2C1);
    for (int j = 0; j < 3; j++) exp_q.push_back(PADW);

    budget = 60;
    while ((level != 0 || flush_busy) && budget > 0) begin
      if (level != 0) begin
        got_q.push_back(ep_datain);
        step(1'b0, 8'h00, 1'b1, 1'b0);
      end else begin
        idle();
      end
      budget--;
    end
    chk("drain_timeout", 32'(budget > 0), 1);
    chk("drain_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("drain_w%0d", i), got_q[i], exp_q[i]);
    end
    chk("drain_drop", 32'(drop_cnt), 3);

    // underflow on empty read
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("uf_flag", 32'(underflow), 1);
    chk("uf_level", 32'(level), 0);

    // reset in the middle of block padding
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    step(1'b1, 8'h04, 1'b0, 1'b0);
    idle();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("pb_busy", 32'(flush_busy), 1);
    idle();
    chk("pb_level", 32'(level), 2);
    chk("pb_busy2", 32'(flush_busy), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_busy", 32'(flush_busy), 0);
    chk("rst2_level", 32'(level), 0);
    chk("rst2_ready", 32'(ep_ready), 0);
    chk("rst2_drop", 32'(drop_cnt), 0);
    chk("rst2_underflow", 32'(underflow), 0);
    chk("rst2_head", ep_datain, 0);
    @(negedge clk);
    reset = 1'b0;
    idle();
    idle();
    chk("rst2_stays_idle", 32'(flush_busy), 0);
    chk("rst2_stays_empty", 32'(level), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
